spi_wb_sequencer: RTL and testbench

- Command sequencer in the system clock domain that turns bytes received by the SPI Mode 0 shift core into Wishbone master transactions.
- Decodes a command/address/data byte stream per chip-select frame and runs single-beat reads and writes.
- Returns read data to the core for transmission on the next byte.
- Sits between the clock-domain-crossed SPI byte interface and the system Wishbone bus arbiter; it is the sole sequencer of that SPI core.

---
 rtl/spi_wb_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_spi_wb_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_wb_sequencer.sv
// SPI byte-stream to single-beat Wishbone master sequencer (cmd/addr/data per CS frame).
// Optional bus timeout: define SPI_WB_TIMEOUT_EN.
module spi_wb_sequencer #(
   parameter int WB_ADDR_WIDTH  = 17,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     spi_cs_ni,
   input  logic                     spi_valid_i,
   input  logic [7:0]               spi_data_i,
   output logic [7:0]               spi_data_o,
   output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
   output logic [7:0]               wb_dat_o,
   input  logic [7:0]               wb_dat_i,
   output logic                     wb_we_o,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   input  logic                     wb_ack_i,
   output logic                     busy_o,
   output logic                     overrun_o,
   output logic                     timeout_o
);

   localparam logic [2:0] ST_CMD     = 3'd0;
   localparam logic [2:0] ST_ADDR_HI = 3'd1;
   localparam logic [2:0] ST_ADDR_LO = 3'd2;
   localparam logic [2:0] ST_DATA    = 3'd3;
   localparam logic [2:0] ST_BUS     = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   localparam logic [1:0] OP_WRITE      = 2'b00;
   localparam logic [1:0] OP_READ       = 2'b01;
   localparam logic [1:0] OP_WRITE_NEXT = 2'b10;

   logic [2:0]               state_r;
   logic [WB_ADDR_WIDTH-1:0] addr_r;
   logic [8:0]               addr_hi_r;   // {addr[16], addr[15:8]} until the low byte commits
   logic                     write_r;
   logic                     cs_end_r;

   logic                     accept_s;
   logic                     start_s;
   logic                     start_we_s;
   logic [WB_ADDR_WIDTH-1:0] start_adr_s;
   logic [WB_ADDR_WIDTH-1:0] full_addr_s;

`ifdef SPI_WB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TW-1:0] tmo_cnt_r;
`else
   assign timeout_o = 1'b0;
`endif

   // A byte only counts while the frame is open and no bus cycle is pending.
   assign accept_s    = spi_valid_i & ~spi_cs_ni & ~wb_cyc_o;
   assign full_addr_s = WB_ADDR_WIDTH'({addr_hi_r, spi_data_i});
   assign busy_o      = wb_cyc_o;

   // Decide whether the byte being accepted launches a bus cycle, and with what.
   always_comb begin
      start_s     = 1'b0;
      start_we_s  = write_r;
      start_adr_s = addr_r;
      if (accept_s) begin
         case (state_r)
            ST_CMD: begin
               start_s    = (spi_data_i[7:6] == 2'b11);
               start_we_s = 1'b0;
            end
            ST_ADDR_LO: begin
               start_s     = ~write_r;
               start_adr_s = full_addr_s;
            end
            ST_DATA: begin
               start_s = 1'b1;
            end
            default: begin
               start_s = 1'b0;
            end
         endcase
      end else begin
         start_s = 1'b0;
      end
   end

   // Sequencer state, address register and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= ST_CMD;
         addr_r     <= '0;
         addr_hi_r  <= 9'd0;
         write_r    <= 1'b0;
         cs_end_r   <= 1'b0;
         spi_data_o <= 8'd0;
         wb_adr_o   <= '0;
         wb_dat_o   <= 8'd0;
         wb_we_o    <= 1'b0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         overrun_o  <= 1'b0;
`ifdef SPI_WB_TIMEOUT_EN
         tmo_cnt_r  <= '0;
         timeout_o  <= 1'b0;
`endif
      end else begin
         if (spi_valid_i && wb_cyc_o) begin
            overrun_o <= 1'b1;
         end
         if (start_s) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= start_we_s;
            wb_adr_o <= start_adr_s;
            cs_end_r <= 1'b0;
`ifdef SPI_WB_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
         end
         case (state_r)
            ST_CMD: begin
               if (accept_s) begin
                  write_r      <= ~spi_data_i[6];
                  addr_hi_r[8] <= spi_data_i[0];
                  case (spi_data_i[7:6])
                     OP_WRITE: begin
                        overrun_o <= 1'b0;
                        state_r   <= ST_ADDR_HI;
                     end
                     OP_READ:       state_r <= ST_ADDR_HI;
                     OP_WRITE_NEXT: state_r <= ST_DATA;
                     default:       state_r <= ST_BUS;
                  endcase
               end
            end
            ST_ADDR_HI: begin
               if (spi_cs_ni) begin
                  state_r <= ST_CMD;
               end else if (accept_s) begin
                  addr_hi_r[7:0] <= spi_data_i;
                  state_r        <= ST_ADDR_LO;
               end
            end
            ST_ADDR_LO: begin
               if (spi_cs_ni) begin
                  state_r <= ST_CMD;
               end else if (accept_s) begin
                  addr_r  <= full_addr_s;
                  state_r <= write_r ? ST_DATA : ST_BUS;
               end
            end
            ST_DATA: begin
               if (spi_cs_ni) begin
                  state_r <= ST_CMD;
               end else if (accept_s) begin
                  wb_dat_o <= spi_data_i;
                  state_r  <= ST_BUS;
               end
            end
            ST_BUS: begin
               // A frame ending mid-cycle is remembered so the cycle can finish first.
               if (spi_cs_ni) begin
                  cs_end_r <= 1'b1;
               end
               if (wb_ack_i) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  if (!wb_we_o) begin
                     spi_data_o <= wb_dat_i;
                  end
                  addr_r  <= addr_r + WB_ADDR_WIDTH'(1);
                  state_r <= (cs_end_r || spi_cs_ni) ? ST_CMD : ST_DONE;
               end
`ifdef SPI_WB_TIMEOUT_EN
               else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
                  timeout_o <= 1'b1;
                  if (!wb_we_o) begin
                     spi_data_o <= 8'hFF;
                  end
                  state_r <= (cs_end_r || spi_cs_ni) ? ST_CMD : ST_DONE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
`endif
            end
            ST_DONE: begin
               if (spi_cs_ni) begin
                  state_r <= ST_CMD;
               end
            end
            default: begin
               state_r <= ST_CMD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Scoreboard bench for spi_wb_sequencer: expected bus cycles are queued by the stimulus,
// a negedge monitor acts as the Wishbone slave and checks each cycle and its read-back.
module tb_spi_wb_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_cs_n;
   logic        spi_valid;
   logic [7:0]  spi_din;
   logic [7:0]  spi_dout;
   logic [16:0] wb_adr;
   logic [7:0]  wb_dat_w;
   logic [7:0]  wb_dat_r;
   logic        wb_we;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_ack;
   logic        busy;
   logic        overrun;
   logic        timeout;

   typedef struct packed {
      logic [16:0] adr;
      logic        we;
      logic [7:0]  dat;
      logic [7:0]  rd;
   } bus_t;

   bus_t exp_q[$];
   bus_t cur;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cycles  = 0;
   int   wait_cnt = 0;
   int   ack_delay = 0;
   bit   ack_en = 1'b1;
   bit   in_cycle = 1'b0;
   bit   ack_pending = 1'b0;

   always #5 clk = ~clk;

   spi_wb_sequencer #(.WB_ADDR_WIDTH(17), .TIMEOUT_CYCLES(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .spi_cs_ni(spi_cs_n), .spi_valid_i(spi_valid),
      .spi_data_i(spi_din), .spi_data_o(spi_dout), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_w),
      .wb_dat_i(wb_dat_r), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
      .wb_ack_i(wb_ack), .busy_o(busy), .overrun_o(overrun), .timeout_o(timeout)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [16:0] adr, input logic we, input logic [7:0] dat,
                       input logic [7:0] rd);
      bus_t e;
      e.adr = adr; e.we = we; e.dat = dat; e.rd = rd;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      spi_din   = b;
      spi_valid = 1'b1;
      @(negedge clk);
      spi_valid = 1'b0;
   endtask

   task automatic frame_end();
      @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((wb_cyc || in_cycle || ack_pending || exp_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: bus never went idle, %0d cycles still expected", name, exp_q.size());
      end
      @(negedge clk);
   endtask

   // Wishbone slave model and scoreboard checker.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_cycle    = 1'b0;
         ack_pending = 1'b0;
         wb_ack      = 1'b0;
      end else if (ack_pending) begin
         wb_ack      = 1'b0;
         ack_pending = 1'b0;
         in_cycle    = 1'b0;
         chk("cyc_drop_after_ack", {63'd0, wb_cyc}, 64'd0);
         if (!cur.we) chk("read_data_to_spi", {56'd0, spi_dout}, {56'd0, cur.rd});
      end else begin
         if (in_cycle && !wb_cyc) begin
            in_cycle = 1'b0;
         end else if (!in_cycle && wb_cyc && wb_stb) begin
            cycles++;
            in_cycle = 1'b1;
            wait_cnt = 0;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_cycle: got adr 0x%0h we %0b, expected no cycle", wb_adr, wb_we);
               cur = '0;
               cur.we = wb_we;
            end else begin
               cur = exp_q.pop_front();
               chk("bus_adr", {47'd0, wb_adr}, {47'd0, cur.adr});
               chk("bus_we", {63'd0, wb_we}, {63'd0, cur.we});
               if (cur.we) chk("bus_dat", {56'd0, wb_dat_w}, {56'd0, cur.dat});
            end
         end
         if (in_cycle && ack_en) begin
            if (wait_cnt >= ack_delay) begin
               wb_dat_r    = cur.rd;
               wb_ack      = 1'b1;
               ack_pending = 1'b1;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   initial begin
      int c0;
      int hi_cnt;
      rst_n = 1'b0; spi_cs_n = 1'b1; spi_valid = 1'b0; spi_din = 8'd0;
      wb_dat_r = 8'd0; wb_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {25'd0, spi_dout, wb_adr, wb_dat_w, wb_we, wb_cyc, wb_stb, busy, overrun, timeout},
          64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      spi_cs_n = 1'b0;

      // WRITE 0x18000 then WRITE_NEXT proves addr_q advanced to 0x18001
      push(17'h18000, 1'b1, 8'h5A, 8'h00);
      send(8'h01); send(8'h80); send(8'h00); send(8'h5A);
      chk("stb_latency_write", {63'd0, wb_stb}, 64'd1);
      wait_idle("write");
      frame_end();
      push(17'h18001, 1'b1, 8'h77, 8'h00);
      send(8'h80); send(8'h77);
      wait_idle("write_next");
      frame_end();

      // READ 0x01234 then READ_NEXT 0x01235
      push(17'h01234, 1'b0, 8'h00, 8'hA5);
      send(8'h40); send(8'h12); send(8'h34);
      chk("stb_latency_read", {63'd0, wb_stb}, 64'd1);
      wait_idle("read");
      frame_end();
      push(17'h01235, 1'b0, 8'h00, 8'h3C);
      send(8'hC0);
      chk("busy_during_cycle", {63'd0, busy}, 64'd1);
      wait_idle("read_next");
      // bytes after the cycle in the same frame are ignored
      c0 = cycles;
      send(8'h40); send(8'h12); send(8'h34);
      repeat (3) @(negedge clk);
      chk("done_ignores_bytes", cycles, c0);
      chk("done_holds_spi_data", {56'd0, spi_dout}, 64'h3C);
      frame_end();

      // address wrap 0x1FFFF -> 0x00000
      push(17'h1FFFF, 1'b1, 8'h22, 8'h00);
      send(8'h01); send(8'hFF); send(8'hFF); send(8'h22);
      wait_idle("wrap_write");
      frame_end();
      push(17'h00000, 1'b1, 8'h11, 8'h00);
      send(8'h80); send(8'h11);
      wait_idle("wrap_write_next");
      frame_end();

      // overrun: byte strobed while the read cycle waits for a slow ack
      ack_delay = 10;
      c0 = cycles;
      push(17'h00020, 1'b0, 8'h00, 8'h66);
      send(8'h40); send(8'h00); send(8'h20);
      repeat (2) @(negedge clk);
      send(8'h55);
      wait_idle("overrun_read");
      chk("overrun_set", {63'd0, overrun}, 64'd1);
      chk("overrun_one_cycle", cycles, c0 + 1);
      ack_delay = 0;
      frame_end();

      // op 00 command clears overrun; CS abort discards the partial command
      send(8'h00);
      chk("overrun_cleared", {63'd0, overrun}, 64'd0);
      send(8'h12);
      frame_end();
      c0 = cycles;
      repeat (4) @(negedge clk);
      chk("cs_abort_no_cycle", cycles, c0);
      push(17'h00010, 1'b0, 8'h00, 8'hC3);
      send(8'h40); send(8'h00); send(8'h10);
      wait_idle("after_cs_abort");
      frame_end();

      // CS high together with a strobe: byte discarded
      c0 = cycles;
      @(negedge clk);
      spi_cs_n = 1'b1; spi_din = 8'hC0; spi_valid = 1'b1;
      @(negedge clk);
      spi_valid = 1'b0;
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("cs_wins_over_valid", cycles, c0);

`ifdef SPI_WB_TIMEOUT_EN
      ack_en = 1'b0;
      push(17'h00100, 1'b0, 8'h00, 8'h00);
      send(8'h40); send(8'h01); send(8'h00);
      hi_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (wb_cyc) hi_cnt++;
         @(negedge clk);
      end
      chk("timeout_cyc_length", hi_cnt, 16);
      chk("timeout_flag", {63'd0, timeout}, 64'd1);
      chk("timeout_spi_data", {56'd0, spi_dout}, 64'hFF);
      ack_en = 1'b1;
      frame_end();
      push(17'h00100, 1'b0, 8'h00, 8'h5E);
      send(8'hC0);
      wait_idle("after_timeout");
      frame_end();
`else
      hi_cnt = 0;
      chk("timeout_tied_low", {63'd0, timeout}, {32'd0, hi_cnt});
`endif

      // reset asserted mid-cycle abandons the cycle asynchronously
      ack_en = 1'b0;
      push(17'h00030, 1'b0, 8'h00, 8'h00);
      send(8'h40); send(8'h00); send(8'h30);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs",
             {25'd0, spi_dout, wb_adr, wb_dat_w, wb_we, wb_cyc, wb_stb, busy, overrun, timeout}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      ack_en = 1'b1;
      push(17'h00000, 1'b0, 8'h00, 8'h99);
      send(8'hC0);
      wait_idle("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
